// File: rtl/branch_ctrl_id.sv
// ID-stage BEQ/BNE/J resolver. It computes the target, drives the PC select and IF/ID flush,
// stalls the front end while a branch operand is still in flight, and counts taken transfers.
module branch_ctrl_id #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              is_jump,
  input  logic [PC_W-1:0]   pc_plus1,
  input  logic [31:0]       sign_ext,
  input  logic [25:0]       jump_index,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_rd,
  output logic              stall,
  output logic              pc_src,
  output logic [PC_W-1:0]   target,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] taken_count_q;

  logic             is_branch;
  logic             ex_match, mem_match;
  logic [1:0]       hazard_n;
  logic             operands_eq;
  logic             branch_taken;
  logic [PC_W-1:0]  offset_pc;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  jump_target;
  logic             stall_raw, resolve, taken;

  assign is_branch = is_beq | is_bne;

  // Register $0 never carries a real dependency.
  assign ex_match  = (ex_rd != 5'd0) && ((ex_rd == rs_addr) || (ex_rd == rt_addr));
  assign mem_match = (mem_rd != 5'd0) && ((mem_rd == rs_addr) || (mem_rd == rt_addr));

  always_comb begin
    hazard_n = 2'd0;
    if (ex_mem_read && ex_match) begin
      hazard_n = 2'd2;
    end else if ((ex_reg_write && ex_match) || (mem_mem_read && mem_match)) begin
      hazard_n = 2'd1;
    end
  end

  assign operands_eq  = (rs_data == rt_data);
  assign branch_taken = (is_beq & operands_eq) | (is_bne & ~operands_eq);

  // Word-addressed PC: the offset is added unshifted.
  assign offset_pc     = PC_W'($signed(sign_ext));
  assign branch_target = pc_plus1 + offset_pc;
  assign jump_target   = {pc_plus1[PC_W-1:26], jump_index};
  assign target        = is_branch ? branch_target : jump_target;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_raw  = 1'b0;
    resolve    = 1'b0;
    taken      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (id_valid) begin
          if (is_jump) begin
            resolve = 1'b1;
            taken   = 1'b1;
          end else if (is_branch) begin
            if (hazard_n == 2'd0) begin
              resolve = 1'b1;
              taken   = branch_taken;
            end else begin
              stall_raw  = 1'b1;
              wait_cnt_d = hazard_n - 2'd1;
              state_d    = StWait;
            end
          end
        end
      end
      StWait: begin
        if (!id_valid) begin
          // Instruction was squashed upstream; drop it silently.
          wait_cnt_d = 2'd0;
          state_d    = StIdle;
        end else if (wait_cnt_q != 2'd0) begin
          stall_raw  = 1'b1;
          wait_cnt_d = wait_cnt_q - 2'd1;
        end else begin
          resolve = 1'b1;
          taken   = is_jump | branch_taken;
          state_d = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        wait_cnt_d = 2'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held.
  assign stall       = stall_raw & ~reset;
  assign pc_src      = resolve & taken & ~reset;
  assign flush_ifid  = resolve & taken & ~reset;
  assign taken_count = taken_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= 2'd0;
      taken_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (resolve && taken) begin
        taken_count_q <= taken_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl_id.sv
// Directed bench for branch_ctrl_id: same-cycle resolves, hazard stalls, flush/reset abort
// and taken-counter wrap, each against hand-computed values.
module tb_branch_ctrl_id;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, is_beq, is_bne, is_jump;
  logic [31:0] pc_plus1, sign_ext;
  logic [25:0] jump_index;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic [4:0]  ex_rd, mem_rd;
  logic        stall, pc_src, flush_ifid;
  logic [31:0] target;
  logic [15:0] taken_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl_id #(
    .PC_W  (32),
    .DATA_W(32),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .is_beq      (is_beq),
    .is_bne      (is_bne),
    .is_jump     (is_jump),
    .pc_plus1    (pc_plus1),
    .sign_ext    (sign_ext),
    .jump_index  (jump_index),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .mem_mem_read(mem_mem_read),
    .mem_rd      (mem_rd),
    .stall       (stall),
    .pc_src      (pc_src),
    .target      (target),
    .flush_ifid  (flush_ifid),
    .taken_count (taken_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; is_beq = 0; is_bne = 0; is_jump = 0;
    pc_plus1 = 0; sign_ext = 0; jump_index = 0;
    rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0;
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rsd, input logic [31:0] rtd);
    clear_inputs();
    id_valid = 1; is_beq = 1;
    rs_addr = rs; rt_addr = rt; rs_data = rsd; rt_data = rtd;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    id_valid = 1; is_jump = 1;
    #2;
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_pc_src", {31'b0, pc_src}, 0);
    check("rst_flush", {31'b0, flush_ifid}, 0);
    check("rst_count", {16'b0, taken_count}, 0);
    step();
    reset = 0;
    clear_inputs();
    step();

    // BEQ taken, backward offset, no hazards
    set_beq(5'd1, 5'd2, 32'd5, 32'd5);
    pc_plus1 = 32'h10; sign_ext = 32'hFFFF_FFFC;
    #1;
    check("beq_pc_src", {31'b0, pc_src}, 1);
    check("beq_target", target, 32'h0C);
    check("beq_flush", {31'b0, flush_ifid}, 1);
    check("beq_stall", {31'b0, stall}, 0);
    step();
    clear_inputs();
    #1;
    check("beq_count", {16'b0, taken_count}, 1);

    // BNE with equal operands: not taken
    clear_inputs();
    id_valid = 1; is_bne = 1; rs_addr = 1; rt_addr = 2; rs_data = 7; rt_data = 7;
    #1;
    check("bne_eq_pc_src", {31'b0, pc_src}, 0);
    check("bne_eq_flush", {31'b0, flush_ifid}, 0);
    step();
    clear_inputs();
    #1;
    check("bne_eq_count", {16'b0, taken_count}, 1);

    // BNE with differing operands, forward offset
    id_valid = 1; is_bne = 1; rs_addr = 1; rt_addr = 2; rs_data = 7; rt_data = 8;
    pc_plus1 = 32'h20; sign_ext = 32'h5;
    #1;
    check("bne_ne_pc_src", {31'b0, pc_src}, 1);
    check("bne_ne_target", target, 32'h25);
    step();
    clear_inputs();
    #1;
    check("bne_ne_count", {16'b0, taken_count}, 2);

    // Load-use in EX: two stall cycles, resolve in the third on updated data
    set_beq(5'd3, 5'd4, 32'd1, 32'd9);
    ex_mem_read = 1; ex_rd = 3;
    #1;
    check("ld_c1_stall", {31'b0, stall}, 1);
    check("ld_c1_pc_src", {31'b0, pc_src}, 0);
    step();
    check("ld_c2_stall", {31'b0, stall}, 1);
    check("ld_c2_pc_src", {31'b0, pc_src}, 0);
    step();
    rs_data = 9;
    #1;
    check("ld_c3_stall", {31'b0, stall}, 0);
    check("ld_c3_pc_src", {31'b0, pc_src}, 1);
    check("ld_c3_flush", {31'b0, flush_ifid}, 1);
    step();
    clear_inputs();
    #1;
    check("ld_count", {16'b0, taken_count}, 3);

    // ALU result in EX: one stall cycle, then resolve not-taken
    set_beq(5'd3, 5'd4, 32'd1, 32'd2);
    ex_reg_write = 1; ex_rd = 3;
    #1;
    check("alu_c1_stall", {31'b0, stall}, 1);
    step();
    check("alu_c2_stall", {31'b0, stall}, 0);
    check("alu_c2_pc_src", {31'b0, pc_src}, 0);
    step();
    clear_inputs();
    #1;
    check("alu_count", {16'b0, taken_count}, 3);

    // Load in MEM matching rt: one stall cycle, then taken
    set_beq(5'd5, 5'd4, 32'd6, 32'd6);
    mem_mem_read = 1; mem_rd = 4;
    #1;
    check("mem_c1_stall", {31'b0, stall}, 1);
    step();
    check("mem_c2_stall", {31'b0, stall}, 0);
    check("mem_c2_pc_src", {31'b0, pc_src}, 1);
    step();
    clear_inputs();
    #1;
    check("mem_count", {16'b0, taken_count}, 4);

    // Writes to $0 never create a hazard
    set_beq(5'd0, 5'd0, 32'd0, 32'd0);
    ex_reg_write = 1; ex_rd = 0;
    #1;
    check("r0_stall", {31'b0, stall}, 0);
    check("r0_pc_src", {31'b0, pc_src}, 1);
    step();
    clear_inputs();
    #1;
    check("r0_count", {16'b0, taken_count}, 5);

    // Jump keeps upper PC bits
    id_valid = 1; is_jump = 1; pc_plus1 = 32'h4000_0001; jump_index = 26'h0000123;
    #1;
    check("j_target", target, 32'h4000_0123);
    check("j_pc_src", {31'b0, pc_src}, 1);
    check("j_stall", {31'b0, stall}, 0);
    step();
    id_valid = 0;
    #1;
    check("j_invalid_pc_src", {31'b0, pc_src}, 0);
    check("j_count", {16'b0, taken_count}, 6);
    clear_inputs();

    // Reset during WAIT abandons the branch
    set_beq(5'd3, 5'd4, 32'd2, 32'd2);
    ex_mem_read = 1; ex_rd = 3;
    step();
    check("rw_wait_stall", {31'b0, stall}, 1);
    reset = 1;
    #1;
    check("rw_stall", {31'b0, stall}, 0);
    check("rw_pc_src", {31'b0, pc_src}, 0);
    check("rw_count", {16'b0, taken_count}, 0);
    step();
    reset = 0;
    clear_inputs();
    step();
    check("rw_post_pc_src", {31'b0, pc_src}, 0);
    check("rw_post_count", {16'b0, taken_count}, 0);

    // id_valid dropped in WAIT: back to IDLE without resolving
    set_beq(5'd3, 5'd4, 32'd2, 32'd2);
    ex_mem_read = 1; ex_rd = 3;
    step();
    id_valid = 0;
    #1;
    check("fl_stall", {31'b0, stall}, 0);
    check("fl_pc_src", {31'b0, pc_src}, 0);
    step();
    set_beq(5'd1, 5'd2, 32'd4, 32'd4);
    #1;
    check("fl_idle_stall", {31'b0, stall}, 0);
    check("fl_idle_pc_src", {31'b0, pc_src}, 1);
    step();
    clear_inputs();
    #1;
    check("fl_count", {16'b0, taken_count}, 1);

    // Counter wrap: clear, 65535 taken jumps, then one more
    reset = 1;
    step();
    reset = 0;
    id_valid = 1; is_jump = 1;
    repeat (65535) step();
    id_valid = 0;
    #1;
    check("wrap_full", {16'b0, taken_count}, 32'hFFFF);
    id_valid = 1;
    step();
    id_valid = 0;
    #1;
    check("wrap_zero", {16'b0, taken_count}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl_id.md
# branch_ctrl_id

ID-stage branch/jump controller for the 5-stage pipeline. Resolves BEQ/BNE/J in decode, computes the word-addressed target from the sign-extended offset, and drives PC source select and IF/ID flush. When a branch operand is still being produced by EX or MEM, it stalls the front end for a counted number of cycles, then resolves. It also keeps a taken-branch performance counter.

## Interface
- `PC_W`, 32: PC and target width
- `DATA_W`, 32: register operand width
- `CNT_W`, 16: taken-counter width

- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `id_valid` in 1: ID holds a valid instruction
- `is_beq`, `is_bne`, `is_jump` in 1 each: decoded class, at most one high
- `pc_plus1` in PC_W: PC of the ID instruction + 1 (word-addressed)
- `sign_ext` in 32: sign-extended 16-bit offset
- `jump_index` in 26: J-format index
- `rs_addr`, `rt_addr` in 5: branch source registers
- `rs_data`, `rt_data` in DATA_W: register-file read data (write-through)
- `ex_reg_write` in 1, `ex_mem_read` in 1, `ex_rd` in 5: EX-stage destination info
- `mem_mem_read` in 1, `mem_rd` in 5: MEM-stage load destination
- `stall` out 1: freeze PC and IF/ID
- `pc_src` out 1: 1 selects `target`
- `target` out PC_W: branch or jump target
- `flush_ifid` out 1: squash the instruction in IF/ID
- `taken_count` out CNT_W: number of taken branches and jumps

## Operation
- Branch target is `pc_plus1 + sign_ext`, unshifted, because the PC advances by one per instruction. Truncate to PC_W bits; overflow wraps.
- Jump target is `{pc_plus1[PC_W-1:26], jump_index}`.
- `target` shows the branch target when `is_beq` or `is_bne` is high, otherwise the jump target. It is combinational and valid whenever `pc_src` = 1.
- Hazard depth N applies only to BEQ/BNE. A register matches when it equals `rs_addr` or `rt_addr` and is nonzero.
  - N = 2 if `ex_mem_read` is high and `ex_rd` matches.
  - Otherwise N = 1 if (`ex_reg_write` and `ex_rd` matches) or (`mem_mem_read` and `mem_rd` matches).
  - Otherwise N = 0.
- Taken condition: BEQ when `rs_data` == `rt_data`; BNE when they differ. J is always taken.
- The FSM has states IDLE and WAIT, plus a 2-bit register `wait_cnt`.
- IDLE:
  - J with `id_valid`: resolve in the same cycle.
  - BEQ/BNE with `id_valid` and N = 0: resolve in the same cycle.
  - BEQ/BNE with `id_valid` and N > 0: assert `stall`, load `wait_cnt` with N-1, go to WAIT. No resolve.
  - No valid control instruction: all outputs low.
- WAIT:
  - `wait_cnt` > 0: assert `stall`, decrement.
  - `wait_cnt` = 0: deassert `stall`, resolve using the current `rs_data`/`rt_data`, return to IDLE.
  - `id_valid` low (external flush): return to IDLE immediately, with no resolve and no stall.
- A resolve cycle asserts `pc_src` = `flush_ifid` = taken. It increments `taken_count` at the clock edge when taken; the counter wraps at all-ones.
- EX/MEM hazard inputs are ignored in WAIT.
- `stall` and `pc_src` are never high in the same cycle.

## Timing
- Reset is asynchronous: state = IDLE, `wait_cnt` = 0, `taken_count` = 0. `stall`, `pc_src` and `flush_ifid` are 0 while reset is high.
- Reset during WAIT abandons the branch. Nothing resolves and the counter stays cleared.
- `stall`, `pc_src`, `flush_ifid` and `target` are combinational from the current state and inputs, and settle within the cycle.
- Stall length is exactly N cycles; the resolve happens in cycle N+1 after the branch enters ID.
- Zero-hazard branches and jumps have zero stall cycles and resolve in their first ID cycle.

## Test plan
- BEQ, `rs_data` = `rt_data` = 5, `pc_plus1` = 0x10, `sign_ext` = 0xFFFFFFFC, no hazards -> same cycle: `pc_src` = 1, `target` = 0x0C, `flush_ifid` = 1; `taken_count` goes 0→1.
- BNE, equal operands (7, 7), no hazard -> `pc_src` = 0, `flush_ifid` = 0, `taken_count` unchanged.
- BEQ with `ex_mem_read` = 1 and `ex_rd` = `rs_addr` = 3 -> `stall` high for 2 cycles, resolve in the 3rd cycle on the updated `rs_data`. Same setup with `ex_reg_write` only -> 1 stall cycle.
- `ex_rd` = 0 with `ex_reg_write` = 1, `rs_addr` = 0 -> no stall. J with `pc_plus1` = 0x40000001 and `jump_index` = 0x0000123 -> `target` = 0x40000123, `pc_src` = 1.
- Reset asserted in the 1st WAIT cycle -> outputs go to 0 immediately; FSM returns to IDLE; no resolve after release. Separately, `id_valid` dropped in WAIT -> returns to IDLE with no `pc_src`.
- Preload `taken_count` to all-ones via 65535 taken jumps, then one more -> `taken_count` = 0.
